// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD run controller: default widths and the
// sequencer state encoding.
package gcd_pkg;

   localparam int ARG_W_DEF = 1279;
   localparam int RES_W_DEF = 1284;
   localparam int CNT_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } state_e;

endpackage

// File: rtl/gcd_sequencer.sv
// Run controller between the AXI unpacker and the GCD core: latches operands,
// pulses the core start, counts RUN cycles and holds results/status.
module gcd_sequencer
   import gcd_pkg::*;
#(
   parameter int ARG_W = ARG_W_DEF,
   parameter int RES_W = RES_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             START_REQ,
   input  logic [CNT_W-1:0] MAX_CYCLES,
   input  logic [ARG_W-1:0] ARG_A,
   input  logic [ARG_W-1:0] ARG_B,
   output logic [ARG_W-1:0] GCD_A,
   output logic [ARG_W-1:0] GCD_B,
   output logic             GCD_START,
   input  logic             GCD_DONE,
   input  logic [RES_W-1:0] GCD_BEZOUT_A,
   input  logic [RES_W-1:0] GCD_BEZOUT_B,
   output logic [RES_W-1:0] BEZOUT_A,
   output logic [RES_W-1:0] BEZOUT_B,
   output logic             DONE,
   output logic             BUSY,
   output logic             TIMEOUT,
   output logic [CNT_W-1:0] CYCLES
);

   state_e           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [CNT_W-1:0] r_cycles, w_cycles_nxt;
   logic             r_start, w_start_nxt;
   logic             r_done, w_done_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_timeout, w_timeout_nxt;
   logic             w_accept, w_capture;
   logic [ARG_W-1:0] r_gcd_a, r_gcd_b;
   logic [RES_W-1:0] r_bez_a, r_bez_b;

   // The counter saturates, so a run longer than the counter range reports all-ones.
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_cycles_nxt  = r_cycles;
      w_start_nxt   = 1'b0;
      w_done_nxt    = r_done;
      w_busy_nxt    = r_busy;
      w_timeout_nxt = r_timeout;
      w_accept      = 1'b0;
      w_capture     = 1'b0;
      case (r_state)
         IDLE, FINISH: begin
            if (START_REQ) begin
               w_accept      = 1'b1;
               w_state_nxt   = LAUNCH;
               w_start_nxt   = 1'b1;
               w_done_nxt    = 1'b0;
               w_timeout_nxt = 1'b0;
               w_busy_nxt    = 1'b1;
               w_cnt_nxt     = '0;
            end
         end
         // GCD_DONE may still be high from the previous run, so LAUNCH ignores it.
         LAUNCH: w_state_nxt = RUN;
         RUN: begin
            w_cnt_nxt = w_cnt_inc;
            if (GCD_DONE) begin
               w_capture    = 1'b1;
               w_cycles_nxt = w_cnt_inc;
               w_done_nxt   = 1'b1;
               w_busy_nxt   = 1'b0;
               w_state_nxt  = FINISH;
            end else if ((MAX_CYCLES != '0) && (w_cnt_inc == MAX_CYCLES)) begin
               w_timeout_nxt = 1'b1;
               w_cycles_nxt  = MAX_CYCLES;
               w_done_nxt    = 1'b1;
               w_busy_nxt    = 1'b0;
               w_state_nxt   = FINISH;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_cycles  <= '0;
         r_start   <= 1'b0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cycles  <= w_cycles_nxt;
         r_start   <= w_start_nxt;
         r_done    <= w_done_nxt;
         r_busy    <= w_busy_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_gcd_a <= '0;
         r_gcd_b <= '0;
         r_bez_a <= '0;
         r_bez_b <= '0;
      end else begin
         if (w_accept) begin
            r_gcd_a <= ARG_A;
            r_gcd_b <= ARG_B;
         end
         if (w_capture) begin
            r_bez_a <= GCD_BEZOUT_A;
            r_bez_b <= GCD_BEZOUT_B;
         end
      end
   end

   assign GCD_A     = r_gcd_a;
   assign GCD_B     = r_gcd_b;
   assign GCD_START = r_start;
   assign BEZOUT_A  = r_bez_a;
   assign BEZOUT_B  = r_bez_b;
   assign DONE      = r_done;
   assign BUSY      = r_busy;
   assign TIMEOUT   = r_timeout;
   assign CYCLES    = r_cycles;

endmodule

// File: tb/tb_gcd_sequencer.sv
// Directed bench for gcd_sequencer: a scripted core model drives GCD_DONE and
// expected run results are queued at launch and popped when DONE rises.
module tb_gcd_sequencer;

   localparam int ARG_W = 16;
   localparam int RES_W = 20;
   localparam int CNT_W = 8;
   localparam int EW    = 1 + CNT_W + 2 * RES_W;

   logic             CLK = 1'b0;
   logic             RESETn = 1'b0;
   logic             START_REQ = 1'b0;
   logic [CNT_W-1:0] MAX_CYCLES = '0;
   logic [ARG_W-1:0] ARG_A = '0;
   logic [ARG_W-1:0] ARG_B = '0;
   logic [ARG_W-1:0] GCD_A, GCD_B;
   logic             GCD_START;
   logic             GCD_DONE = 1'b0;
   logic [RES_W-1:0] GCD_BEZOUT_A = '0;
   logic [RES_W-1:0] GCD_BEZOUT_B = '0;
   logic [RES_W-1:0] BEZOUT_A, BEZOUT_B;
   logic             DONE, BUSY, TIMEOUT;
   logic [CNT_W-1:0] CYCLES;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   gcd_sequencer #(.ARG_W(ARG_W), .RES_W(RES_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESETn(RESETn), .START_REQ(START_REQ), .MAX_CYCLES(MAX_CYCLES),
      .ARG_A(ARG_A), .ARG_B(ARG_B), .GCD_A(GCD_A), .GCD_B(GCD_B),
      .GCD_START(GCD_START), .GCD_DONE(GCD_DONE),
      .GCD_BEZOUT_A(GCD_BEZOUT_A), .GCD_BEZOUT_B(GCD_BEZOUT_B),
      .BEZOUT_A(BEZOUT_A), .BEZOUT_B(BEZOUT_B), .DONE(DONE), .BUSY(BUSY),
      .TIMEOUT(TIMEOUT), .CYCLES(CYCLES)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic to, input logic [CNT_W-1:0] cyc,
                           input logic [RES_W-1:0] a, input logic [RES_W-1:0] b);
      exp_q.push_back({to, cyc, a, b});
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_gcd_a"}, 32'(GCD_A), 0);
      chk({tag, "_gcd_b"}, 32'(GCD_B), 0);
      chk({tag, "_start"}, 32'(GCD_START), 0);
      chk({tag, "_bez_a"}, 32'(BEZOUT_A), 0);
      chk({tag, "_bez_b"}, 32'(BEZOUT_B), 0);
      chk({tag, "_done"}, 32'(DONE), 0);
      chk({tag, "_busy"}, 32'(BUSY), 0);
      chk({tag, "_timeout"}, 32'(TIMEOUT), 0);
      chk({tag, "_cycles"}, 32'(CYCLES), 0);
   endtask

   task automatic launch(input logic [ARG_W-1:0] a, input logic [ARG_W-1:0] b);
      ARG_A = a;
      ARG_B = b;
      START_REQ = 1'b1;
      tick();
      START_REQ = 1'b0;
      chk("launch_start", 32'(GCD_START), 1);
      chk("launch_busy", 32'(BUSY), 1);
      chk("launch_done_clr", 32'(DONE), 0);
      chk("launch_timeout_clr", 32'(TIMEOUT), 0);
      chk("launch_gcd_a", 32'(GCD_A), 32'(a));
      chk("launch_gcd_b", 32'(GCD_B), 32'(b));
   endtask

   task automatic check_result();
      logic [EW-1:0] e;
      chk("result_done", 32'(DONE), 1);
      chk("result_busy", 32'(BUSY), 0);
      chk("sb_pending", 32'(exp_q.size()), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("result_timeout", 32'(TIMEOUT), 32'(e[EW-1]));
         chk("result_cycles", 32'(CYCLES), 32'(e[EW-2 -: CNT_W]));
         chk("result_bez_a", 32'(BEZOUT_A), 32'(e[2*RES_W-1 -: RES_W]));
         chk("result_bez_b", 32'(BEZOUT_B), 32'(e[RES_W-1:0]));
      end
   endtask

   // Called right after the LAUNCH edge; the core completes on RUN cycle k.
   task automatic core_done(input int k, input logic [RES_W-1:0] ba, input logic [RES_W-1:0] bb);
      tick();
      chk("start_one_cycle", 32'(GCD_START), 0);
      repeat (k - 1) tick();
      chk("pre_done_low", 32'(DONE), 0);
      GCD_BEZOUT_A = ba;
      GCD_BEZOUT_B = bb;
      GCD_DONE = 1'b1;
      tick();
      GCD_DONE = 1'b0;
      check_result();
   endtask

   task automatic wait_done(input int exp_ticks, input int budget);
      int n = 0;
      while (DONE !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk("done_latency", 32'(n), 32'(exp_ticks));
      check_result();
   endtask

   initial begin
      // Reset
      tick();
      tick();
      check_all_zero("reset");
      RESETn = 1'b1;
      tick();

      // Basic run: done on 5th RUN cycle
      push_exp(1'b0, 8'd5, 20'd1, 20'hFFFFE);
      launch(16'd35, 16'd15);
      core_done(5, 20'd1, 20'hFFFFE);

      // Timeout with the core never finishing; results must not change
      MAX_CYCLES = 8'd10;
      GCD_BEZOUT_A = 20'd77;
      GCD_BEZOUT_B = 20'd88;
      push_exp(1'b1, 8'd10, 20'd1, 20'hFFFFE);
      launch(16'd7, 16'd3);
      wait_done(11, 20);
      tick();
      tick();
      chk("finish_hold_done", 32'(DONE), 1);
      chk("finish_hold_timeout", 32'(TIMEOUT), 1);
      chk("finish_hold_cycles", 32'(CYCLES), 10);

      // Stale GCD_DONE held through LAUNCH completes on first RUN cycle
      GCD_DONE = 1'b1;
      GCD_BEZOUT_A = 20'd5;
      GCD_BEZOUT_B = 20'd6;
      push_exp(1'b0, 8'd1, 20'd5, 20'd6);
      launch(16'd12, 16'd8);
      wait_done(2, 6);
      GCD_DONE = 1'b0;

      // Done and timeout coincide: done wins
      MAX_CYCLES = 8'd4;
      push_exp(1'b0, 8'd4, 20'd9, 20'd10);
      launch(16'd21, 16'd14);
      core_done(4, 20'd9, 20'd10);
      MAX_CYCLES = 8'd0;

      // Mid-run START_REQ and ARG_A change are ignored
      push_exp(1'b0, 8'd6, 20'd11, 20'd12);
      launch(16'd100, 16'd200);
      tick();
      tick();
      START_REQ = 1'b1;
      ARG_A = 16'd999;
      tick();
      START_REQ = 1'b0;
      chk("midrun_no_start", 32'(GCD_START), 0);
      chk("midrun_gcd_a", 32'(GCD_A), 100);
      chk("midrun_busy", 32'(BUSY), 1);
      repeat (3) tick();
      GCD_BEZOUT_A = 20'd11;
      GCD_BEZOUT_B = 20'd12;
      GCD_DONE = 1'b1;
      tick();
      GCD_DONE = 1'b0;
      check_result();

      // Back-to-back: START_REQ in first FINISH cycle
      push_exp(1'b0, 8'd2, 20'd13, 20'd14);
      launch(16'd555, 16'd222);
      core_done(2, 20'd13, 20'd14);

      // Counter saturation with timeout disabled
      push_exp(1'b0, 8'd255, 20'd21, 20'd22);
      launch(16'd3, 16'd5);
      core_done(300, 20'd21, 20'd22);

      // Reset mid-run with count 7, then a normal run
      launch(16'd1, 16'd2);
      repeat (8) tick();
      chk("pre_reset_busy", 32'(BUSY), 1);
      RESETn = 1'b0;
      tick();
      check_all_zero("midrun_reset");
      chk("midrun_reset_state", 32'(dut.r_state), 0);
      RESETn = 1'b1;
      tick();
      push_exp(1'b0, 8'd3, 20'd31, 20'd32);
      launch(16'd8, 16'd9);
      core_done(3, 20'd31, 20'd32);

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gcd_sequencer.md
# gcd_sequencer

Run controller between the AXI unpacker and the GCD datapath core. It latches the operand pair presented by the unpacker and issues a one-cycle start pulse to the core. It then counts cycles until the core signals completion or a programmable timeout expires, and holds the Bézout results and status stable for the unpacker to read back.

## Interface

Parameters:
- ARG_W, 1279, operand width (ARG_A/ARG_B).
- RES_W, 1284, result width (BEZOUT_A/BEZOUT_B).
- CNT_W, 32, cycle counter and timeout width.

Ports:
- CLK  in  1  clock; one clock domain.
- RESETn  in  1  reset, synchronous, active-low.
- START_REQ  in  1  run request pulse from unpacker.
- MAX_CYCLES  in  CNT_W  timeout limit; 0 disables timeout.
- ARG_A  in  ARG_W  operand A from unpacker.
- ARG_B  in  ARG_W  operand B from unpacker.
- GCD_A  out  ARG_W  latched operand A to core.
- GCD_B  out  ARG_W  latched operand B to core.
- GCD_START  out  1  one-cycle start pulse to core.
- GCD_DONE  in  1  core completion, level.
- GCD_BEZOUT_A  in  RES_W  core result A.
- GCD_BEZOUT_B  in  RES_W  core result B.
- BEZOUT_A  out  RES_W  captured result A to unpacker.
- BEZOUT_B  out  RES_W  captured result B to unpacker.
- DONE  out  1  run finished, held until next accepted START_REQ.
- BUSY  out  1  run in progress.
- TIMEOUT  out  1  last run ended by timeout.
- CYCLES  out  CNT_W  cycles spent in RUN for last run.

## Operation

- FSM states: IDLE, LAUNCH, RUN, FINISH.
- IDLE and FINISH accept START_REQ. On acceptance:
  - GCD_A <= ARG_A and GCD_B <= ARG_B.
  - DONE, TIMEOUT <= 0; BUSY <= 1.
  - Cycle counter <= 0; state -> LAUNCH.
- LAUNCH: GCD_START = 1 for exactly this cycle. GCD_DONE is ignored here, because a stale level from the previous run is possible. State -> RUN.
- RUN: the counter increments every cycle and saturates at all-ones.
  - If GCD_DONE = 1: BEZOUT_A/B <= GCD_BEZOUT_A/B, CYCLES <= counter+1, DONE <= 1, BUSY <= 0; state -> FINISH.
  - Else if MAX_CYCLES != 0 and counter+1 == MAX_CYCLES: TIMEOUT <= 1, DONE <= 1, BUSY <= 0, CYCLES <= MAX_CYCLES; BEZOUT_A/B keep their previous values; state -> FINISH.
  - GCD_DONE and timeout in the same cycle: done wins, TIMEOUT = 0.
- START_REQ in LAUNCH or RUN is ignored and not queued.
- GCD_A/GCD_B stay stable from LAUNCH until the next accepted START_REQ; ARG_A/ARG_B changes mid-run have no effect.
- BEZOUT_A/B, CYCLES, DONE and TIMEOUT stay stable in FINISH.
- Reset, including mid-run: state IDLE; every output 0 (GCD_A, GCD_B, GCD_START, BEZOUT_A, BEZOUT_B, DONE, BUSY, TIMEOUT, CYCLES).

## Timing

- All outputs are registered; no combinational input-to-output path.
- START_REQ high at edge N -> BUSY = 1 and GCD_START = 1 during cycle N+1.
- First RUN cycle is N+2.
- GCD_DONE sampled high at edge M in RUN -> DONE, BEZOUT and CYCLES valid after edge M.
- CYCLES = number of RUN cycles including the completing one. Core asserting DONE on its first RUN cycle -> CYCLES = 1.
- Back-to-back runs: START_REQ in the first FINISH cycle is accepted, and DONE drops on the next edge.
- Throughput: one run per (CYCLES + 2) cycles minimum.

## Structure

- Shared package `gcd_pkg`: ARG_W/RES_W defaults, state enum (IDLE, LAUNCH, RUN, FINISH), CNT_W default.
- Single module; no sub-modules.
- Wide operand/result latches are plain enable registers.
- The GCD wrapper top instantiates this block beside the AXI unpacker.

## Test plan

- Reset then ARG_A=35, ARG_B=15, START_REQ pulse; core model asserts GCD_DONE on the 5th RUN cycle with GCD_BEZOUT_A=1, GCD_BEZOUT_B=-2 -> GCD_START exactly one cycle, CYCLES=5, BEZOUT_A=1, BEZOUT_B=-2, DONE=1, TIMEOUT=0.
- MAX_CYCLES=10, core never done -> DONE=1, TIMEOUT=1, CYCLES=10 exactly 11 cycles after the LAUNCH cycle, and BEZOUT unchanged.
- GCD_DONE held high from the previous run through LAUNCH -> not captured in LAUNCH; completes on the first RUN cycle with CYCLES=1.
- GCD_DONE and timeout coincide with MAX_CYCLES=4 and done on RUN cycle 4 -> TIMEOUT=0, CYCLES=4, results captured.
- START_REQ pulsed mid-RUN and ARG_A changed mid-RUN -> GCD_A unchanged and no second GCD_START; START_REQ in the first FINISH cycle launches a new run with the new ARG_A.
- RESETn low during RUN with count=7 -> next cycle all outputs 0, state IDLE; a subsequent START_REQ runs normally.
